// File: rtl/cic3_decim.sv
// Third-order CIC (sinc^3) decimator: 1-bit delta-sigma stream in, 16-bit PCM out at fs/R.
// Optional output saturation is enabled by defining CIC_SAT_EN.
module cic3_decim #(
  parameter int LOG2R  = 4,
  parameter int ACC_W  = 3 * LOG2R + 2,
  parameter int OSHIFT = 15 - 3 * LOG2R
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] out,
  output logic        out_valid
);

`ifdef CIC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  logic        [ACC_W-1:0] integ1_r, integ2_r, integ3_r;
  logic        [ACC_W-1:0] d1_r, d2_r, d3_r;
  logic        [LOG2R-1:0] cnt_r;
  logic        [15:0]      out_r;
  logic                    out_valid_r;
  state_t                  state_r, state_s;
  logic        [1:0]       fill_r, fill_s;
  logic                    load_s;
  logic                    wrap_s;
  logic        [ACC_W-1:0] x_s;
  logic        [ACC_W-1:0] v0_s, c1_s, c2_s;
  logic signed [ACC_W-1:0] c3_s;
  logic signed [31:0]      y_s;

  // Clamp to the 16-bit range when saturation is built in; otherwise plain truncation.
  function automatic logic [15:0] scale_f(input logic signed [31:0] y);
    logic [15:0] r;
    if (SAT_EN && (y > 32'sd32767)) begin
      r = 16'h7FFF;
    end else if (SAT_EN && (y < -32'sd32768)) begin
      r = 16'h8000;
    end else begin
      r = y[15:0];
    end
    return r;
  endfunction

  // Combinational datapath: input mapping, wrap detect and the comb cascade on integ3's next value.
  always_comb begin
    x_s    = bit_in ? ACC_W'(1'b1) : {ACC_W{1'b1}};
    wrap_s = en && (cnt_r == {LOG2R{1'b1}});
    v0_s   = integ3_r + integ2_r;
    c1_s   = v0_s - d1_r;
    c2_s   = c1_s - d2_r;
    c3_s   = c2_s - d3_r;
    y_s    = 32'(c3_s) <<< OSHIFT;
  end

  // Integrators, phase counter and comb delays; all hold while en is low.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      integ1_r <= {ACC_W{1'b0}};
      integ2_r <= {ACC_W{1'b0}};
      integ3_r <= {ACC_W{1'b0}};
      d1_r     <= {ACC_W{1'b0}};
      d2_r     <= {ACC_W{1'b0}};
      d3_r     <= {ACC_W{1'b0}};
      cnt_r    <= {LOG2R{1'b0}};
    end else if (en) begin
      integ1_r <= integ1_r + x_s;
      integ2_r <= integ2_r + integ1_r;
      integ3_r <= v0_s;
      cnt_r    <= cnt_r + LOG2R'(1'b1);
      if (wrap_s) begin
        d1_r <= v0_s;
        d2_r <= c1_s;
        d3_r <= c2_s;
      end
    end
  end

  // FSM state register: FILL until the comb delays are primed, then RUN.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= FILL;
      fill_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      fill_r  <= fill_s;
    end
  end

  // FSM next state; the third wrap edge in FILL moves to RUN, wrap edges in RUN load out.
  always_comb begin
    state_s = state_r;
    fill_s  = fill_r;
    load_s  = 1'b0;
    case (state_r)
      FILL: begin
        if (wrap_s) begin
          fill_s = fill_r + 2'd1;
          if (fill_r == 2'd2) begin
            state_s = RUN;
          end else begin
            state_s = FILL;
          end
        end else begin
          fill_s = fill_r;
        end
      end
      RUN: begin
        if (wrap_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_s = FILL;
        fill_s  = 2'd0;
      end
    endcase
  end

  // Output word and its one-cycle valid strobe.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      out_r       <= 16'h0000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= load_s;
      if (load_s) begin
        out_r <= scale_f(y_s);
      end
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_cic3_decim.sv
// Self-checking bench for cic3_decim: frame-sum sinc^3 reference model plus directed literal checks.
module tb_cic3_decim;
  localparam int R = 16;
`ifdef CIC_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
`else
  localparam logic [15:0] EXP_POS = 16'h8000;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        en;
  logic        bit_in;
  logic [15:0] out;
  logic        out_valid;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // reference model state
  int          hist[$];
  int          n_en;
  logic        exp_valid;
  logic [15:0] exp_out;

  // stimulus-side observations
  int          stim_edges;
  bit          seen;
  int          first_edge;
  int          first_clk;
  logic [15:0] first_out;
  logic [15:0] last_out;

  cic3_decim dut (
    .CLK      (CLK),
    .reset    (reset),
    .en       (en),
    .bit_in   (bit_in),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 CLK = ~CLK;

  // Three cascaded R-sample moving sums evaluated at en-edge index n. Integrators
  // update from their old values, so a bit reaches the output two en edges later.
  function automatic int sinc3_at(input int n);
    int acc = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) begin
          int idx = n - a - b - c - 2;
          if (idx >= 0) acc += hist[idx];
        end
    return acc;
  endfunction

  function automatic logic [15:0] to16(input int m);
    int y = m * 8;
`ifdef CIC_SAT_EN
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
`endif
    return y[15:0];
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      hist.delete();
      n_en      <= 0;
      exp_valid <= 1'b0;
      exp_out   <= 16'h0000;
    end else if (en) begin
      hist.push_back(bit_in ? 1 : -1);
      n_en <= n_en + 1;
      if (((n_en + 1) % R == 0) && (n_en + 1 >= 4 * R)) begin
        exp_valid <= 1'b1;
        exp_out   <= to16(sinc3_at(n_en));
      end else begin
        exp_valid <= 1'b0;
      end
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      vectors++;
      if (out_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_valid);
      end
      vectors++;
      if (out !== exp_out) begin
        miscompares++;
        $display("FAIL out @%0t: got %h expected %h", $time, out, exp_out);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int nclk);
    @(negedge CLK);
    reset = 1'b0; en = 1'b0; bit_in = 1'b0;
    repeat (nclk) @(negedge CLK);
    reset = 1'b1;
    stim_edges = 0; seen = 1'b0; first_edge = 0; first_clk = 0;
  endtask

  // mode: 0 all zeros, 1 all ones, 2 alternating 1010, 3 repeating 1110, else random
  task automatic drive(input int nclk, input int mode, input bit toggle);
    for (int i = 0; i < nclk; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        last_out = out;
        if (!seen) begin
          seen = 1'b1; first_edge = stim_edges; first_clk = i; first_out = out;
        end
      end
      en = toggle ? 1'((i % 2) == 0) : 1'b1;
      case (mode)
        0: bit_in = 1'b0;
        1: bit_in = 1'b1;
        2: bit_in = 1'((stim_edges % 2) == 0);
        3: bit_in = 1'((stim_edges % 4) != 3);
        default: bit_in = 1'($urandom_range(0, 1));
      endcase
      if (en) stim_edges++;
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; bit_in = 1'b0;
    do_reset(3);
    chk_on = 1'b1;
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);

    // constant +1
    drive(64 + 48 + 2, 1, 1'b0);
    check("s1_first_edge", first_edge, 64);
    check("s1_first_clk", first_clk, 64);
    check("s1_first_out", {16'h0, first_out}, {16'h0, EXP_POS});
    check("s1_last_out", {16'h0, last_out}, {16'h0, EXP_POS});

    // constant -1
    do_reset(2);
    drive(64 + 32 + 2, 0, 1'b0);
    check("s2_first_edge", first_edge, 64);
    check("s2_first_out", {16'h0, first_out}, 32'h8000);

    // alternating and 1110 patterns
    do_reset(2);
    drive(64 + 32 + 2, 2, 1'b0);
    check("s3a_seen", {31'h0, seen}, 32'h1);
    check("s3a_last_out", {16'h0, last_out}, 32'h0000);
    do_reset(2);
    drive(64 + 32 + 2, 3, 1'b0);
    check("s3b_first_out", {16'h0, first_out}, 32'h4000);
    check("s3b_last_out", {16'h0, last_out}, 32'h4000);

    // en toggling: counts en edges, not clocks
    do_reset(2);
    drive(2 * (64 + 32) + 2, 1, 1'b1);
    check("s4_first_edge", first_edge, 64);
    check("s4_first_clk", first_clk, 127);
    check("s4_first_out", {16'h0, first_out}, {16'h0, EXP_POS});

    // mid-frame async reset at cnt=7 of the 5th frame
    do_reset(2);
    drive(64 + 7, 1, 1'b0);
    @(negedge CLK);
    check("s5_pre_out", {16'h0, out}, {16'h0, EXP_POS});
    #2 reset = 1'b0;
    #1;
    check("s5_async_out", {16'h0, out}, 32'h0);
    check("s5_async_valid", {31'h0, out_valid}, 32'h0);
    @(negedge CLK);
    reset = 1'b1; en = 1'b0;
    stim_edges = 0; seen = 1'b0; first_edge = 0; first_clk = 0;
    drive(64 + 16 + 2, 1, 1'b0);
    check("s5_first_edge", first_edge, 64);
    check("s5_first_clk", first_clk, 64);

    // random bitstream against the reference model
    do_reset(2);
    drive(4096 + 2, 4, 1'b0);
    check("s6_seen", {31'h0, seen}, 32'h1);

    @(negedge CLK);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
